// File: rtl/multdiv.sv
// Iterative signed multiply/divide unit.
// Shift-add multiply and restoring divide, fixed 33-cycle latency.
module multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_mul;
  logic             neg;
  logic             dz;
  logic             ovf;
  logic [WIDTH-1:0] opnd;
  logic [W2-1:0]    acc;
  logic [WIDTH:0]   rem;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             start;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             div_bit;
  logic [WIDTH:0]   div_rem;
  logic [W2-1:0]    mag;
  logic [W2-1:0]    sres;
  logic [WIDTH-1:0] fin_result;
  logic             fin_exc;
  logic [WIDTH:0]   top_bits;

  assign start = ctrl_MULT | ctrl_DIV;
  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // One iteration step for both datapaths plus final sign correction
  always_comb begin
    mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted  = {rem[WIDTH-1:0], acc[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    div_bit  = ~diff[WIDTH];
    div_rem  = div_bit ? diff : shifted;
    mag      = is_mul ? acc : {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
    sres     = neg ? -mag : mag;
    top_bits = sres[W2-1:WIDTH-1];
    fin_result = dz ? '0 : sres[WIDTH-1:0];
    fin_exc    = is_mul ? ~((&top_bits) | ~(|top_bits)) : (dz | ovf);
  end

  // Control FSM, iteration registers and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      is_mul         <= 1'b0;
      neg            <= 1'b0;
      dz             <= 1'b0;
      ovf            <= 1'b0;
      opnd           <= '0;
      acc            <= '0;
      rem            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (start) begin
      state          <= RUN;
      cnt            <= '0;
      is_mul         <= ctrl_MULT;
      neg            <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz             <= ~ctrl_MULT & (data_operandB == '0);
      ovf            <= ~ctrl_MULT
                        & (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                        & (&data_operandB);
      opnd           <= ctrl_MULT ? abs_a : abs_b;
      acc            <= {{WIDTH{1'b0}}, (ctrl_MULT ? abs_b : abs_a)};
      rem            <= '0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
    end else begin
      data_resultRDY <= 1'b0;
      unique case (state)
        RUN: begin
          if (is_mul) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            rem <= div_rem;
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_bit};
          end
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
          else cnt <= cnt + 1'b1;
        end
        DONE: begin
          data_result    <= fin_result;
          data_exception <= fin_exc;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Directed self-checking bench for multdiv.
// Checks latency, results, exceptions, restart and reset abort.
module tb_multdiv;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks;
  int errors;

  multdiv dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a start pulse so that the next rising edge is E0
  task automatic kick(input logic mul, input logic [31:0] a,
                      input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mul;
    ctrl_DIV      = ~mul;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic mul,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_e);
    int early;
    int idle;
    early = 0;
    idle  = 0;
    kick(mul, a, b);
    chk({tag, "_busy0"}, {31'b0, busy}, 32'd1);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) early++;
      if (!busy) idle++;
    end
    chk({tag, "_early"}, early, 0);
    chk({tag, "_busy"}, idle, 0);
    @(posedge clock);
    #1;
    chk({tag, "_rdy"}, {31'b0, data_resultRDY}, 32'd1);
    chk({tag, "_bsy33"}, {31'b0, busy}, 32'd0);
    chk({tag, "_res"}, data_result, exp_r);
    chk({tag, "_exc"}, {31'b0, data_exception}, {31'b0, exp_e});
    @(posedge clock);
    #1;
    chk({tag, "_rdy34"}, {31'b0, data_resultRDY}, 32'd0);
    chk({tag, "_hold"}, data_result, exp_r);
  endtask

  initial begin
    int pulses;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_res", data_result, 32'h0);
    chk("rst_exc", {31'b0, data_exception}, 32'd0);
    chk("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("mul_neg",  1'b1, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0);
    run_op("mul_ovf",  1'b1, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    run_op("mul_min",  1'b1, 32'hFFFF8000, 32'h00010000, 32'h80000000, 1'b0);
    run_op("mul_zero", 1'b1, 32'd0,        32'hFFFFFFFF, 32'h00000000, 1'b0);
    run_op("div_na",   1'b0, 32'hFFFFFFD5, 32'd5,        32'hFFFFFFF8, 1'b0);
    run_op("div_nb",   1'b0, 32'd43,       32'hFFFFFFFB, 32'hFFFFFFF8, 1'b0);
    run_op("div_z",    1'b0, 32'd100,      32'd0,        32'h00000000, 1'b1);
    run_op("div_ovf",  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op("div_min2", 1'b0, 32'h80000000, 32'd2,        32'hC0000000, 1'b0);
    run_op("div_zero", 1'b0, 32'd0,        32'd7,        32'h00000000, 1'b0);
    run_op("div_pos",  1'b0, 32'd1000,     32'd7,        32'd142,      1'b0);

    // Restart: DIV at E10 aborts the MULT started at E0
    kick(1'b1, 32'd3, 32'd4);
    pulses = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    kick(1'b0, 32'd20, 32'd4);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    chk("rs_none", pulses, 0);
    @(posedge clock);
    #1;
    chk("rs_rdy", {31'b0, data_resultRDY}, 32'd1);
    chk("rs_res", data_result, 32'd5);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    chk("rs_after", pulses, 0);

    // Reset between E5 and E6 of a divide
    kick(1'b0, 32'd9, 32'd3);
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("ar_res", data_result, 32'h0);
    chk("ar_busy", {31'b0, busy}, 32'd0);
    chk("ar_exc", {31'b0, data_exception}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY || busy) pulses++;
    end
    chk("ar_quiet", pulses, 0);
    run_op("mul_2x2", 1'b1, 32'd2, 32'd2, 32'd4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
